// File: rtl/alu_exec_pkg.sv
// Shared types and decode helper for the ALU execute stage.
package alu_exec_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SRA  = 4'b1000,
        OP_SLTU = 4'b1001,
        OP_MUL  = 4'b1010,
        OP_DIV  = 4'b1100,
        OP_DIVU = 4'b1101,
        OP_REM  = 4'b1110,
        OP_REMU = 4'b1111
    } alu_op_e;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ITER = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef struct packed {
        alu_op_e op;
        logic    illegal;
    } dec_t;

    // Map ALUOp/funct7/funct3 onto the extended op code; unknown encodings flag illegal.
    function automatic dec_t decode_op(input logic [1:0] alu_op, input logic [6:0] funct7,
                                       input logic [2:0] funct3, input logic mext);
        dec_t d;
        d.op      = OP_ADD;
        d.illegal = 1'b0;
        case (alu_op)
            ALUOP_MEM: d.op = OP_ADD;
            ALUOP_BR:  d.op = OP_SUB;
            ALUOP_R: begin
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            3'b000:  d.op = OP_ADD;
                            3'b001:  d.op = OP_SLL;
                            3'b010:  d.op = OP_SLT;
                            3'b011:  d.op = OP_SLTU;
                            3'b100:  d.op = OP_XOR;
                            3'b101:  d.op = OP_SRL;
                            3'b110:  d.op = OP_OR;
                            3'b111:  d.op = OP_AND;
                            default: d.illegal = 1'b1;
                        endcase
                    end
                    F7_ALT: begin
                        case (funct3)
                            3'b000:  d.op = OP_SUB;
                            3'b101:  d.op = OP_SRA;
                            default: d.illegal = 1'b1;
                        endcase
                    end
                    F7_MEXT: begin
                        if (mext) begin
                            case (funct3)
                                3'b000:  d.op = OP_MUL;
                                3'b100:  d.op = OP_DIV;
                                3'b101:  d.op = OP_DIVU;
                                3'b110:  d.op = OP_REM;
                                3'b111:  d.op = OP_REMU;
                                default: d.illegal = 1'b1;
                            endcase
                        end else begin
                            d.illegal = 1'b1;
                        end
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
            ALUOP_I: begin
                case (funct3)
                    3'b000: d.op = OP_ADD;
                    3'b001: begin
                        if (funct7 == F7_BASE) d.op = OP_SLL;
                        else                   d.illegal = 1'b1;
                    end
                    3'b010: d.op = OP_SLT;
                    3'b011: d.op = OP_SLTU;
                    3'b100: d.op = OP_XOR;
                    3'b101: begin
                        // funct7[5] is instruction bit 30: arithmetic vs logical shift
                        if ({funct7[6], funct7[4:0]} == 6'b000000) d.op = funct7[5] ? OP_SRA : OP_SRL;
                        else                                       d.illegal = 1'b1;
                    end
                    3'b110:  d.op = OP_OR;
                    3'b111:  d.op = OP_AND;
                    default: d.illegal = 1'b1;
                endcase
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Request/result handshake bundle between register-read, execute and writeback.
interface alu_exec_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, alu_op, funct7, funct3, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alu_op, funct7, funct3, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_exec_unit_muldiv_iter.sv
// Iterative RV32M engine: shift-add multiply and restoring divide sharing one shift register.
module muldiv_iter
    import alu_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  alu_op_e         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST_MUL = CW'(XLEN - 1);
    localparam logic [CW-1:0] FIX_DIV  = CW'(XLEN);

    logic            busy_q, is_div_q, want_rem_q, qneg_q, rneg_q, bzero_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] acc_q, sr_q, opb_q;

    logic [XLEN:0]   trial_s, diff_s;
    logic [XLEN-1:0] acc_step_s, sr_step_s, opb_step_s, q_fix_s, r_fix_s;
    logic            start_div_s, start_sgn_s, a_neg_s, b_neg_s;

    // One iteration step, final sign fix and done/result selection.
    always_comb begin
        trial_s    = {acc_q, sr_q[XLEN-1]};
        diff_s     = trial_s - {1'b0, opb_q};
        acc_step_s = acc_q;
        sr_step_s  = sr_q;
        opb_step_s = opb_q;
        if (is_div_q) begin
            // Borrow out of the trial subtraction means restore
            if (!diff_s[XLEN]) begin
                acc_step_s = diff_s[XLEN-1:0];
                sr_step_s  = {sr_q[XLEN-2:0], 1'b1};
            end else begin
                acc_step_s = trial_s[XLEN-1:0];
                sr_step_s  = {sr_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_step_s = sr_q[0] ? (acc_q + opb_q) : acc_q;
            sr_step_s  = sr_q >> 1;
            opb_step_s = opb_q << 1;
        end
        q_fix_s = bzero_q ? {XLEN{1'b1}} : (qneg_q ? -sr_q : sr_q);
        r_fix_s = rneg_q ? -acc_q : acc_q;
        done_o  = busy_q && (is_div_q ? (cnt_q == FIX_DIV) : (cnt_q == LAST_MUL));
        // Multiply hands over its last partial sum directly; divide hands over the fixed-up value
        if (is_div_q) result_o = want_rem_q ? r_fix_s : q_fix_s;
        else          result_o = acc_step_s;
    end

    // Operand classification at start.
    always_comb begin
        start_div_s = (op_i[3:2] == 2'b11);
        start_sgn_s = (op_i == OP_DIV) || (op_i == OP_REM);
        a_neg_s     = start_sgn_s && a_i[XLEN-1];
        b_neg_s     = start_sgn_s && b_i[XLEN-1];
    end

    // Load on start, iterate while busy, release when the result is handed over.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q     <= 1'b0;
            is_div_q   <= 1'b0;
            want_rem_q <= 1'b0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            bzero_q    <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            sr_q       <= '0;
            opb_q      <= '0;
        end else if (start_i) begin
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            is_div_q   <= start_div_s;
            want_rem_q <= (op_i == OP_REM) || (op_i == OP_REMU);
            qneg_q     <= a_neg_s ^ b_neg_s;
            rneg_q     <= a_neg_s;
            bzero_q    <= (b_i == '0);
            acc_q      <= '0;
            if (start_div_s) begin
                sr_q  <= a_neg_s ? -a_i : a_i;
                opb_q <= b_neg_s ? -b_i : b_i;
            end else begin
                sr_q  <= b_i;
                opb_q <= a_i;
            end
        end else if (busy_q) begin
            if (done_o) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
                acc_q <= acc_step_s;
                sr_q  <= sr_step_s;
                opb_q <= opb_step_s;
            end
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// Registered decode-plus-execute stage with valid/ready handshakes on both sides.
module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int MEXT = 1
) (
    input  logic       clk,
    input  logic       rst,
    alu_exec_if.slave  bus
);
    import alu_exec_pkg::*;

    localparam int SHW = $clog2(XLEN);

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d, illegal_q, illegal_d;

    dec_t            dec_s;
    logic            is_md_s, md_start_s, md_done_s;
    logic [XLEN-1:0] alu_s, md_result_s;
    logic [SHW-1:0]  shamt_s;

    // Decode and single-cycle datapath straight from the request.
    always_comb begin
        dec_s   = decode_op(bus.alu_op, bus.funct7, bus.funct3, (MEXT != 0));
        is_md_s = !dec_s.illegal && ((dec_s.op == OP_MUL) || (dec_s.op[3:2] == 2'b11));
        shamt_s = bus.src_b[SHW-1:0];
        case (dec_s.op)
            OP_AND:  alu_s = bus.src_a & bus.src_b;
            OP_OR:   alu_s = bus.src_a | bus.src_b;
            OP_ADD:  alu_s = bus.src_a + bus.src_b;
            OP_XOR:  alu_s = bus.src_a ^ bus.src_b;
            OP_SLL:  alu_s = bus.src_a << shamt_s;
            OP_SRL:  alu_s = bus.src_a >> shamt_s;
            OP_SUB:  alu_s = bus.src_a - bus.src_b;
            OP_SLT:  alu_s = {{(XLEN-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
            OP_SRA:  alu_s = $signed(bus.src_a) >>> shamt_s;
            OP_SLTU: alu_s = {{(XLEN-1){1'b0}}, (bus.src_a < bus.src_b)};
            default: alu_s = '0;
        endcase
    end

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (md_start_s),
        .op_i     (dec_s.op),
        .a_i      (bus.src_a),
        .b_i      (bus.src_b),
        .done_o   (md_done_s),
        .result_o (md_result_s)
    );

    // Next-state and output-register logic.
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        zero_d     = zero_q;
        illegal_d  = illegal_q;
        md_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (dec_s.illegal) begin
                        result_d  = '0;
                        zero_d    = 1'b1;
                        illegal_d = 1'b1;
                        state_d   = ST_DONE;
                    end else if (is_md_s) begin
                        md_start_s = 1'b1;
                        illegal_d  = 1'b0;
                        state_d    = ST_ITER;
                    end else begin
                        result_d  = alu_s;
                        zero_d    = (alu_s == '0);
                        illegal_d = 1'b0;
                        state_d   = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (md_done_s) begin
                    result_d = md_result_s;
                    zero_d   = (md_result_s == '0);
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_ITER;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
                else               state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; reset discards any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (MEXT=1 main instance, MEXT=0 side instance).
module tb_alu_exec_unit;
    import alu_exec_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_exec_if #(.XLEN(32)) bus ();
    alu_exec_if #(.XLEN(32)) bus_nm ();

    alu_exec_unit #(.XLEN(32), .MEXT(1)) dut    (.clk(clk), .rst(rst), .bus(bus));
    alu_exec_unit #(.XLEN(32), .MEXT(0)) dut_nm (.clk(clk), .rst(rst), .bus(bus_nm));

    int errors = 0;
    int checks = 0;

    logic [31:0] obs_res;
    logic        obs_zero, obs_ill, obs_rdy_hi, saw_valid;
    int          obs_lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.alu_op   = op;
        bus.funct7   = f7;
        bus.funct3   = f3;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Count negedges after the accept edge until out_valid is seen (bounded).
    task automatic wait_result();
        obs_lat    = 0;
        obs_rdy_hi = 1'b0;
        do begin
            @(negedge clk);
            obs_lat++;
            if (bus.in_ready) obs_rdy_hi = 1'b1;
        end while (!bus.out_valid && obs_lat < 100);
        obs_res  = bus.result;
        obs_zero = bus.zero;
        obs_ill  = bus.illegal;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [6:0] f7,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
        issue(op, f7, f3, a, b);
        wait_result();
        chk({tag, "_res"}, obs_res, exp_res);
        chk({tag, "_ill"}, 32'(obs_ill), 32'(exp_ill));
        chk({tag, "_lat"}, 32'(obs_lat), 32'(exp_lat));
        chk({tag, "_inrdy_low"}, 32'(obs_rdy_hi), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.alu_op = 2'b00; bus.funct7 = 7'd0; bus.funct3 = 3'd0;
        bus.src_a = 32'd0; bus.src_b = 32'd0;
        bus_nm.in_valid = 1'b0; bus_nm.out_ready = 1'b1;
        bus_nm.alu_op = 2'b00; bus_nm.funct7 = 7'd0; bus_nm.funct3 = 3'd0;
        bus_nm.src_a = 32'd0; bus_nm.src_b = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);

        // Single-cycle ops
        run_op("add", ALUOP_MEM, 7'd0, 3'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1);
        chk("add_zero", 32'(obs_zero), 32'd0);
        run_op("sub", ALUOP_BR, 7'd0, 3'd0, 32'd9, 32'd9, 32'd0, 1'b0, 1);
        chk("sub_zero", 32'(obs_zero), 32'd1);
        run_op("sra", ALUOP_R, 7'b0100000, 3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1);
        run_op("srl", ALUOP_R, 7'b0000000, 3'b101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1);
        run_op("srai", ALUOP_I, 7'b0100000, 3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1);
        run_op("slt", ALUOP_R, 7'd0, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
        run_op("sltu", ALUOP_R, 7'd0, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);

        // Multiply
        run_op("mul_neg", ALUOP_R, 7'b0000001, 3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0, 33);
        run_op("mul_pos", ALUOP_R, 7'b0000001, 3'b000, 32'd123, 32'd456, 32'h0000_DB18, 1'b0, 33);

        // Divide corner cases
        run_op("div_by0", ALUOP_R, 7'b0000001, 3'b100, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 34);
        run_op("rem_by0", ALUOP_R, 7'b0000001, 3'b110, 32'd7, 32'd0, 32'd7, 1'b0, 34);
        run_op("div_ovf", ALUOP_R, 7'b0000001, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 34);
        run_op("rem_ovf", ALUOP_R, 7'b0000001, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 34);
        chk("rem_ovf_zero", 32'(obs_zero), 32'd1);
        run_op("div_neg", ALUOP_R, 7'b0000001, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34);
        run_op("rem_neg", ALUOP_R, 7'b0000001, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 34);
        run_op("divu", ALUOP_R, 7'b0000001, 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 34);
        run_op("remu", ALUOP_R, 7'b0000001, 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 34);

        // Illegal encodings
        run_op("ill_r", ALUOP_R, 7'b0100000, 3'b111, 32'd5, 32'd3, 32'd0, 1'b1, 1);
        run_op("ill_slli", ALUOP_I, 7'b0100000, 3'b001, 32'd5, 32'd3, 32'd0, 1'b1, 1);

        // MEXT=0 instance flags MUL illegal
        @(negedge clk);
        bus_nm.alu_op = ALUOP_R; bus_nm.funct7 = 7'b0000001; bus_nm.funct3 = 3'b000;
        bus_nm.src_a = 32'd3; bus_nm.src_b = 32'd4; bus_nm.in_valid = 1'b1;
        @(posedge clk);
        #1 bus_nm.in_valid = 1'b0;
        @(negedge clk);
        chk("nm_valid", 32'(bus_nm.out_valid), 32'd1);
        chk("nm_illegal", 32'(bus_nm.illegal), 32'd1);
        chk("nm_result", bus_nm.result, 32'd0);
        @(posedge clk);
        #1;

        // Backpressure: hold the result, refuse a new request
        bus.out_ready = 1'b0;
        issue(ALUOP_MEM, 7'd0, 3'd0, 32'd1, 32'd2);
        wait_result();
        chk("bp_res", obs_res, 32'd3);
        bus.src_a = 32'd100;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold", bus.result, 32'd3);
            chk("bp_inrdy", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_inrdy", 32'(bus.in_ready), 32'd1);

        // Reset in the middle of a divide
        issue(ALUOP_R, 7'b0000001, 3'b100, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_inrdy", 32'(bus.in_ready), 32'd1);
        chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) saw_valid = 1'b1;
        end
        chk("rst_mid_no_valid", 32'(saw_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
